// File: rtl/fourphase_rx_fifo.sv
// fourphase_rx_fifo: receive side of a 4-phase req/ack link.
// The asynchronous req passes through a SYNC_STAGES flop synchroniser in the
// clk_rx domain. Bundled in_data is captured into a DEPTH-entry FIFO, and the
// FIFO head is presented on a first-word-fall-through valid/ready port.
// Optional feature macro RX_OVF_DROP_EN: when defined, a request that arrives
// while the FIFO is full is acknowledged and its data discarded, and the
// sticky ovf flag is set. When undefined, a full FIFO stalls the handshake and
// ovf is tied to 0.
module fourphase_rx_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4,
    parameter int ADDR_WIDTH  = 2
) (
    input  logic                  clk_rx,
    input  logic                  reset,
    input  logic                  req,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  ovf
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                  state_q;
    state_t                  state_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    req_s;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   wr_ptr;
    logic [ADDR_WIDTH-1:0]   rd_ptr;
    logic [ADDR_WIDTH:0]     count_q;
    logic                    push;
    logic                    pop;
`ifdef RX_OVF_DROP_EN
    logic                    drop;
    logic                    ovf_q;
`endif

    // Shift req through the synchroniser chain; the last stage is the usable req.
    always_ff @(posedge clk_rx or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking assignment so every stage samples the previous
            // stage's old value on the same edge, giving a true shift chain.
            sync_q <= {sync_q[SYNC_STAGES-2:0], req};
        end
    end

    assign req_s     = sync_q[SYNC_STAGES-1];
    assign full      = (count_q == FULL_COUNT);
    assign empty     = (count_q == '0);
    assign out_valid = !empty;
    assign count     = count_q;
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid && out_ready;
    assign ack       = (state_q == ACK);

    // Handshake state register; ack is decoded directly from this flop.
    always_ff @(posedge clk_rx or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and push decision; the push uses the registered full flag.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d = state_q;
        push    = 1'b0;
`ifdef RX_OVF_DROP_EN
        drop    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    if (!full) begin
                        push    = 1'b1;
                        state_d = ACK;
                    end
`ifdef RX_OVF_DROP_EN
                    else begin
                        drop    = 1'b1;
                        state_d = ACK;
                    end
`endif
                end
            end
            ACK: begin
                if (!req_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO storage, pointers and occupancy; push and pop may share an edge.
    always_ff @(posedge clk_rx or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            // NOTE: the storage is cleared on reset on purpose, so out_data
            // reads 0 while the FIFO is empty after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef RX_OVF_DROP_EN
    // Sticky overflow flag, set whenever a full-FIFO request is dropped.
    always_ff @(posedge clk_rx or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_fourphase_rx_fifo.sv
// tb_fourphase_rx_fifo: drives 4-phase transfers into fourphase_rx_fifo and
// compares every cycle against a queue-based model of the FIFO contents.
module tb_fourphase_rx_fifo;

    localparam int DW    = 8;
    localparam int SS    = 2;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk_rx = 1'b0;
    logic          reset;
    logic          req;
    logic [DW-1:0] in_data;
    logic          ack;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          ovf;

    int            n_vec = 0;
    int            n_bad = 0;
    logic [DW-1:0] model_q[$];
    logic          exp_ovf;
    logic          prev_ack;
    int            ready_mode;

    always #5 clk_rx = ~clk_rx;

    fourphase_rx_fifo #(
        .DATA_WIDTH (DW),
        .SYNC_STAGES(SS),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk_rx   (clk_rx),
        .reset    (reset),
        .req      (req),
        .in_data  (in_data),
        .ack      (ack),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .ovf      (ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: advance the model by what the posedge did, then check outputs.
    task automatic cycle();
        logic          pop_armed;
        logic          full_before;
        logic [DW-1:0] word;
        pop_armed   = out_ready && (model_q.size() > 0);
        full_before = (model_q.size() == DEPTH);
        word        = in_data;
        @(negedge clk_rx);
        if (pop_armed) void'(model_q.pop_front());
        if (ack && !prev_ack) begin
            if (full_before) begin
`ifdef RX_OVF_DROP_EN
                exp_ovf = 1'b1;
`else
                check("ack_while_full", ack, 1'b0);
`endif
            end else begin
                model_q.push_back(word);
            end
        end
        prev_ack = ack;
        check("count", count, model_q.size());
        check("empty", empty, model_q.size() == 0);
        check("full", full, model_q.size() == DEPTH);
        check("out_valid", out_valid, model_q.size() > 0);
        check("ovf", ovf, exp_ovf);
        if (model_q.size() > 0) check("out_data", out_data, model_q[0]);
        case (ready_mode)
            1:       out_ready = ~out_ready;
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = out_ready;
        endcase
    endtask

    // Full 4-phase transfer of one word, with latency checks when not full.
    task automatic send(input logic [DW-1:0] w);
        int k;
        logic not_full;
        not_full = (model_q.size() < DEPTH);
        in_data  = w;
        req      = 1'b1;
        k = 0;
        while (!ack && k < 100) begin cycle(); k++; end
        check("ack_rise", ack, 1'b1);
        if (not_full) check("rise_latency", k <= SS + 1, 1'b1);
        req     = 1'b0;
        in_data = DW'($urandom);
        k = 0;
        while (ack && k < 100) begin cycle(); k++; end
        check("ack_fall", ack, 1'b0);
        check("fall_latency", k <= SS + 1, 1'b1);
    endtask

    task automatic drain();
        int k;
        ready_mode = 0;
        out_ready  = 1'b1;
        k = 0;
        while (model_q.size() > 0 && k < 60) begin cycle(); k++; end
        cycle();
        check("drained", count, 0);
        out_ready = 1'b0;
    endtask

    initial begin
        int k;
        reset      = 1'b1;
        req        = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        ready_mode = 0;
        prev_ack   = 1'b0;
        exp_ovf    = 1'b0;
        #3;
        check("rst_ack", ack, 1'b0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 0);
        check("rst_ovf", ovf, 1'b0);
        repeat (2) @(negedge clk_rx);
        reset = 1'b0;
        cycle();

        // T1: single word with consumer ready
        out_ready = 1'b1;
        send(8'hA5);
        drain();
        check("t1_count", count, 0);

        // T2: fill, then a fifth request against the full FIFO
        for (int i = 1; i <= DEPTH; i++) send(DW'(i));
        check("t2_full", full, 1'b1);
        check("t2_count", count, DEPTH);
`ifdef RX_OVF_DROP_EN
        send(8'hEE);
        check("t6_ovf_set", ovf, 1'b1);
        drain();
        check("t6_ovf_sticky", ovf, 1'b1);
`else
        in_data = 8'h05;
        req     = 1'b1;
        repeat (8) begin
            cycle();
            check("t2_stall", ack, 1'b0);
        end
        out_ready = 1'b1;
        cycle();
        check("t2_ack_pop_edge", ack, 1'b0);
        cycle();
        check("t2_ack_next_edge", ack, 1'b1);
        req = 1'b0;
        k = 0;
        while (ack && k < 20) begin cycle(); k++; end
        check("t2_ack_fall", ack, 1'b0);
        drain();
`endif

        // T3: capture and pop on the same edge at count 2
        send(8'h21);
        send(8'h22);
        check("t3_pre_count", count, 2);
        in_data = 8'h23;
        req     = 1'b1;
        repeat (SS) cycle();
        out_ready = 1'b1;
        cycle();
        check("t3_ack", ack, 1'b1);
        check("t3_count", count, 2);
        out_ready = 1'b0;
        req       = 1'b0;
        k = 0;
        while (ack && k < 20) begin cycle(); k++; end
        drain();

        // T4: ten words with out_ready toggling every cycle
        ready_mode = 1;
        for (int i = 0; i < 10; i++) send(DW'(8'h10 + i));
        drain();

        // Random traffic with random consumer stalls
        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) cycle();
            send(DW'($urandom));
        end
        drain();

        // T5: reset while ack=1 and count=3
        send(8'h31);
        send(8'h32);
        in_data = 8'h33;
        req     = 1'b1;
        k = 0;
        while (!ack && k < 20) begin cycle(); k++; end
        check("t5_pre_ack", ack, 1'b1);
        check("t5_pre_count", count, 3);
        #2;
        reset = 1'b1;
        req   = 1'b0;
        #1;
        check("t5_ack", ack, 1'b0);
        check("t5_count", count, 0);
        check("t5_empty", empty, 1'b1);
        check("t5_data", out_data, 0);
        model_q.delete();
        prev_ack = 1'b0;
        exp_ovf  = 1'b0;
        cycle();
        reset = 1'b0;
        cycle();
        send(8'h44);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
